// File: rtl/mic_buffer_arbiter_pkg.sv
// Shared definitions for the microphone buffer arbiter slice.
// Contents:
//   - default sample width and buffer depth,
//   - FSM state encodings (legacy-compatible constants),
//   - clog2 helper used to size counters from parameters.
package mic_buffer_arbiter_pkg;

  localparam int DATA_WIDTH_DEF  = 9;
  localparam int BUFFER_SIZE_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  // Ceiling log2; clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
  function automatic int clog2(input int value);
    int v;
    int res;
    v   = value - 32'sd1;
    res = 32'sd0;
    while (v > 32'sd0) begin
      res = res + 32'sd1;
      v   = v >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mic_buffer_arbiter_rr_priority_picker.sv
// Round-robin priority picker (combinational).
// Searches req starting at rr_ptr+1, wrapping modulo NUM_CH, and returns the
// first asserted index. The channel at rr_ptr itself is searched last.
// Ports:
//   req     in  NUM_CH  request vector
//   rr_ptr  in  CH_W    last served channel
//   gnt     out CH_W    selected channel (0 when any_req is low)
//   any_req out 1       at least one request asserted
module rr_priority_picker
  import mic_buffer_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [CH_W-1:0]   gnt,
  output logic              any_req
);

  logic [CH_W-1:0] idx_s;

  // Rotating first-one search; the first hit wins, later hits are ignored.
  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    idx_s   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx_s = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!any_req && req[idx_s]) begin
        gnt     = idx_s;
        any_req = 1'b1;
      end else begin
        gnt     = gnt;
        any_req = any_req;
      end
    end
  end

endmodule

// File: rtl/mic_buffer_arbiter.sv
// Arbitrates NUM_CH microphone-sample requesters onto the single write port
// of one channel buffer. Round-robin grant, tagged write word, credit-based
// flow control and an abort for writes the buffer never acknowledges.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    per-channel request, held until req_ack
//   req_data     packed samples, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack      one-cycle accept pulse to the granted channel
//   buf_data     {channel tag, sample} write word
//   buf_valid    write request to the buffer
//   buf_ack      buffer accepted the word
//   buf_rd_done  consumer removed one word (returns a credit)
//   credit       free buffer slots
//   busy         FSM not idle
//   err_timeout  sticky: a write was aborted
//   err_credit   sticky: a credit was returned while already full
module mic_buffer_arbiter
  import mic_buffer_arbiter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CH_W        = 2,
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
  parameter int TIMEOUT     = 15
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       req_data,
  output logic [NUM_CH-1:0]                  req_ack,
  output logic [DATA_WIDTH+CH_W-1:0]         buf_data,
  output logic                               buf_valid,
  input  logic                               buf_ack,
  input  logic                               buf_rd_done,
  output logic [clog2(BUFFER_SIZE+1)-1:0]    credit,
  output logic                               busy,
  output logic                               err_timeout,
  output logic                               err_credit
);

  localparam int CRED_W = clog2(BUFFER_SIZE + 1);
  // One spare count keeps the width >= 1 even for TIMEOUT = 0.
  localparam int TMR_W  = clog2(TIMEOUT + 2);

  logic [1:0]            state_r;
  logic [CH_W-1:0]       rr_ptr_r;
  logic [CH_W-1:0]       gnt_r;
  logic [TMR_W-1:0]      timer_r;
  logic [CH_W-1:0]       pick_gnt_s;
  logic                  pick_any_s;
  logic [DATA_WIDTH-1:0] pick_data_s;
  logic                  accept_s;

  rr_priority_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_r),
    .gnt     (pick_gnt_s),
    .any_req (pick_any_s)
  );

  // Sample of the candidate channel and the buffer-accept strobe.
  always_comb begin
    pick_data_s = req_data[int'(pick_gnt_s)*DATA_WIDTH +: DATA_WIDTH];
    accept_s    = buf_valid & buf_ack;
  end

  // Grant / write-handshake FSM and its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= CH_W'(NUM_CH - 1);
      gnt_r       <= '0;
      timer_r     <= '0;
      req_ack     <= '0;
      buf_data    <= '0;
      buf_valid   <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          req_ack <= '0;
          // credit is read before this edge's update; a returned credit
          // enables the grant one cycle later.
          if (pick_any_s && (credit != '0)) begin
            gnt_r     <= pick_gnt_s;
            buf_data  <= {pick_gnt_s, pick_data_s};
            buf_valid <= 1'b1;
            timer_r   <= '0;
            busy      <= 1'b1;
            state_r   <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (buf_ack) begin
            buf_valid <= 1'b0;
            req_ack   <= {{(NUM_CH-1){1'b0}}, 1'b1} << gnt_r;
            rr_ptr_r  <= gnt_r;
            state_r   <= ST_ACK;
          end else if (timer_r == TMR_W'(TIMEOUT)) begin
            // Abort without moving rr_ptr so the same channel is retried first.
            buf_valid   <= 1'b0;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            timer_r <= timer_r + TMR_W'(32'd1);
          end
        end
        ST_ACK: begin
          req_ack <= '0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          req_ack   <= '0;
          buf_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-slot counter; an accept and a returned slot in one cycle cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit     <= CRED_W'(BUFFER_SIZE);
      err_credit <= 1'b0;
    end else begin
      case ({accept_s, buf_rd_done})
        2'b10: credit <= credit - CRED_W'(32'd1);
        2'b01: begin
          if (credit == CRED_W'(BUFFER_SIZE)) begin
            err_credit <= 1'b1;
          end else begin
            credit <= credit + CRED_W'(32'd1);
          end
        end
        default: credit <= credit;
      endcase
    end
  end

endmodule

// File: doc/mic_buffer_arbiter.md
Name: mic_buffer_arbiter

Overview:
- Shares the single write port of one channel buffer among NUM_CH microphone-sample requesters.
- Grants one requester at a time, round-robin.
- Forwards the requester's sample tagged with its channel index.
- Runs the write handshake, tracks free buffer space with a credit counter, and aborts writes that are never acknowledged.

Parameters:
- NUM_CH, 4, number of requesters; 2..16.
- DATA_WIDTH, 9, sample width.
- CH_W, 2, channel tag width; must satisfy CH_W = clog2(NUM_CH).
- BUFFER_SIZE, 16, downstream buffer depth; initial credit count.
- TIMEOUT, 15, maximum ISSUE cycles before a write is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_CH  per-channel request; held high until that channel's req_ack.
- req_data  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; stable while req_valid is high.
- req_ack  out  NUM_CH  one-cycle accept pulse to the granted channel.
- buf_data  out  DATA_WIDTH+CH_W  {channel tag, sample} to the buffer.
- buf_valid  out  1  write request to the buffer.
- buf_ack  in  1  buffer accepted the word.
- buf_rd_done  in  1  one-cycle pulse when the consumer removes one word.
- credit  out  clog2(BUFFER_SIZE+1)  free slots.
- busy  out  1  high when the state is not IDLE.
- err_timeout  out  1  sticky abort flag.
- err_credit  out  1  sticky credit-overflow flag.

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ack=0, buf_data=0, buf_valid=0, busy=0.
  - credit=BUFFER_SIZE.
  - err_timeout=0, err_credit=0.
  - state=IDLE, rr_ptr=NUM_CH-1, timer=0.
- Reset mid-operation:
  - The pending write is dropped with no req_ack.
  - Credits are restored to BUFFER_SIZE.
  - Requesters keep req_valid high and are re-served after reset.
- State IDLE:
  - A grant requires at least one req_valid and credit>0.
  - Select the first asserted channel searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - On grant: latch gnt, buf_data<={gnt,req_data[gnt]}, buf_valid<=1, timer<=0, go ISSUE.
  - When credit=0, no grant is issued and requests wait.
- State ISSUE:
  - buf_data and buf_valid hold while waiting.
  - If buf_ack=1: buf_valid<=0, req_ack[gnt]<=1, rr_ptr<=gnt, go ACK.
  - Else if timer=TIMEOUT: buf_valid<=0, err_timeout<=1, go IDLE. No req_ack; rr_ptr is unchanged, so the same channel is retried first.
  - Else timer<=timer+1.
  - buf_ack outside ISSUE is ignored.
- State ACK:
  - req_ack<=0, go IDLE.
  - The requester drops or updates req_valid at the edge that ends ACK.
- Latency:
  - req_valid rising in IDLE to buf_valid: 1 cycle.
  - buf_ack to req_ack: 1 cycle.
  - Minimum 3 cycles per word, giving a peak throughput of 1 word per 3 clocks.
- Credits:
  - Decrement on buf_valid && buf_ack.
  - Increment on buf_rd_done.
  - Both in the same cycle: credit is unchanged.
  - buf_rd_done with credit=BUFFER_SIZE and no accept in that cycle: credit saturates and err_credit<=1.
  - Credit never underflows, because no grant is issued at 0.
- Fairness: a channel that holds req_valid is served within NUM_CH grants, provided credit is available.
- Errors are cleared only by rst.

Decomposition:
- Shared package:
  - DATA_WIDTH, BUFFER_SIZE defaults.
  - State encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_ACK=2'd2.
  - clog2 function.
- Natural sub-module: rr_priority_picker.
  - Combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: gnt index and any_req.
  - Reused by later readout arbiters.

Test Plan:
- Single channel: req_valid=4'b0100, req_data[2]=9'h1A5, buf_ack on the first ISSUE cycle -> buf_data={2'd2,9'h1A5} one cycle after request; req_ack=4'b0100 for exactly 1 cycle; credit 16->15.
- Round-robin: all four req_valid held high, buf_ack always 1 -> grant order 0,1,2,3,0; each req_ack is 1 cycle wide; words spaced 3 cycles apart.
- Full buffer: 16 accepts with no buf_rd_done -> credit=0, buf_valid stays 0 while requests pend. One buf_rd_done pulse -> credit=1, and the next grant occurs within 1 cycle.
- Timeout: buf_ack held 0 with TIMEOUT=15 -> buf_valid high for 16 cycles, then drops; err_timeout=1; no req_ack; the same channel is re-granted next.
- Simultaneous credit events: accept and buf_rd_done in the same cycle -> credit unchanged. buf_rd_done at credit=16 -> credit stays 16, err_credit=1.
- Reset mid-ISSUE: rst asserted while buf_valid=1 -> next cycle buf_valid=0, credit=16, state IDLE, no req_ack. The held request is regranted with ch0 priority.
